// File: rtl/gemm_result_writer.sv
// Result writer for the GeMM controller: buffers result words in a small FIFO and
// drains them to the output SRAM in row-major order at base + m*stride + n.
module gemm_result_writer #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [AddrWidth-1:0] stride_i,
    input  logic                 result_valid_i,
    input  logic [DataWidth-1:0] result_data_i,
    output logic                 stall_o,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        Idle,
        Run,
        Done
    } state_e;

    state_e state, state_next;

    logic [DataWidth-1:0] fifo_mem [FifoDepth];
    logic [PtrW-1:0]      rd_ptr, wr_ptr;
    logic [CntW-1:0]      count;

    logic [AddrWidth-1:0] m_size, n_size, stride;
    logic [AddrWidth-1:0] m_cnt, n_cnt, row_addr;
    logic                 error;

    logic run_st, start_acc, fifo_empty, fifo_full;
    logic pop, push, drop, row_wrap, last_xfer;

    always_comb begin
        run_st     = (state == Run);
        start_acc  = (state == Idle) && start_i;
        fifo_empty = (count == '0);
        fifo_full  = (count == CntW'(FifoDepth));
        pop        = run_st && !fifo_empty && mem_ready_i;
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        push       = run_st && result_valid_i && (!fifo_full || pop);
        drop       = result_valid_i && !push;
        row_wrap   = (n_cnt == n_size - AddrWidth'(1));
        last_xfer  = pop && row_wrap && (m_cnt == m_size - AddrWidth'(1));
    end

    always_comb begin
        state_next = state;
        case (state)
            Idle: begin
                if (start_i) begin
                    state_next = (M_size_i == '0 || N_size_i == '0) ? Done : Run;
                end
            end
            Run: begin
                if (last_xfer) state_next = Done;
            end
            Done:    state_next = Idle;
            default: state_next = Idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= Idle;
        else         state <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            m_size   <= '0;
            n_size   <= '0;
            stride   <= '0;
            m_cnt    <= '0;
            n_cnt    <= '0;
            row_addr <= '0;
            error    <= 1'b0;
        end else if (start_acc) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            m_size   <= M_size_i;
            n_size   <= N_size_i;
            stride   <= stride_i;
            m_cnt    <= '0;
            n_cnt    <= '0;
            row_addr <= base_addr_i;
            // A word arriving alongside start is still a drop and must be reported.
            error    <= drop;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            count <= count + CntW'(push) - CntW'(pop);
            if (pop) begin
                if (row_wrap) begin
                    n_cnt    <= '0;
                    m_cnt    <= m_cnt + AddrWidth'(1);
                    row_addr <= row_addr + stride;
                end else begin
                    n_cnt <= n_cnt + AddrWidth'(1);
                end
            end
            if (drop) error <= 1'b1;
        end
    end

    // Storage only; occupancy is tracked by the reset pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= result_data_i;
    end

    always_comb begin
        mem_valid_o = run_st && !fifo_empty;
        mem_addr_o  = mem_valid_o ? (row_addr + n_cnt) : '0;
        mem_wdata_o = mem_valid_o ? fifo_mem[rd_ptr] : '0;
        stall_o     = run_st && (count >= CntW'(FifoDepth - 1));
        busy_o      = run_st;
        done_o      = (state == Done);
        error_o     = error;
    end

endmodule

// File: tb/tb_gemm_result_writer.sv
// Randomized and directed bench for gemm_result_writer against a queue-based
// reference model of the write stream, compared every cycle.
module tb_gemm_result_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] msz = '0, nsz = '0, base = '0, stride = '0;
    logic        rv = 1'b0;
    logic [31:0] rdata = '0;
    logic        ready = 1'b0;

    logic        stall, mem_valid, busy, done, error;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;

    gemm_result_writer #(
        .DataWidth(32),
        .AddrWidth(16),
        .FifoDepth(4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .M_size_i      (msz),
        .N_size_i      (nsz),
        .base_addr_i   (base),
        .stride_i      (stride),
        .result_valid_i(rv),
        .result_data_i (rdata),
        .stall_o       (stall),
        .mem_valid_o   (mem_valid),
        .mem_ready_i   (ready),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .busy_o        (busy),
        .done_o        (done),
        .error_o       (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: job bookkeeping plus a queue of words awaiting write.
    bit          m_run = 0, m_done = 0, m_err = 0;
    int unsigned m_M = 0, m_N = 0, m_base = 0, m_stride = 0;
    int unsigned m_k = 0;
    logic [31:0] m_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_addr(input int unsigned k);
        int unsigned a;
        a = m_base + (k / m_N) * m_stride + (k % m_N);
        return a[15:0];
    endfunction

    task automatic model_step();
        bit out_valid, popped, accept;
        out_valid = m_run && (m_q.size() > 0);
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_err = 0; m_k = 0;
            m_q.delete();
        end else if (m_run) begin
            popped = out_valid && ready;
            accept = rv && (m_q.size() < 4 || popped);
            if (popped) begin
                void'(m_q.pop_front());
                m_k++;
                if (m_k == m_M * m_N) begin
                    m_run = 0;
                    m_done = 1;
                end
            end
            if (accept)  m_q.push_back(rdata);
            else if (rv) m_err = 1;
        end else if (m_done) begin
            m_done = 0;
            if (rv) m_err = 1;
        end else begin
            if (start) begin
                m_M = msz; m_N = nsz; m_base = base; m_stride = stride;
                m_k = 0; m_err = 0;
                m_q.delete();
                if (msz == 0 || nsz == 0) m_done = 1;
                else                      m_run = 1;
            end
            if (rv) m_err = 1;
        end
    endtask

    // Compare outputs mid-cycle, then let the model and DUT take the same edge.
    task automatic tick();
        bit ev;
        @(negedge clk);
        ev = m_run && (m_q.size() > 0);
        check_eq("mem_valid", 32'(mem_valid), 32'(ev));
        check_eq("mem_addr", 32'(mem_addr), ev ? 32'(exp_addr(m_k)) : 32'h0);
        check_eq("mem_wdata", mem_wdata, ev ? m_q[0] : 32'h0);
        check_eq("stall", 32'(stall), 32'(m_run && m_q.size() >= 3));
        check_eq("busy", 32'(busy), 32'(m_run));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("error", 32'(error), 32'(m_err));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit st, input bit v, input bit rdy);
        start = st;
        rv    = v;
        rdata = $urandom;
        ready = rdy;
        tick();
        start = 1'b0;
        rv    = 1'b0;
    endtask

    task automatic setup(input int unsigned M, input int unsigned N,
                         input int unsigned b, input int unsigned s);
        msz = 16'(M); nsz = 16'(N); base = 16'(b); stride = 16'(s);
    endtask

    task automatic finish_job(input bit rdy);
        for (int c = 0; c < 60 && (m_run || m_done); c++) drive(0, 0, rdy);
        drive(0, 0, rdy);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) drive(0, 0, 0);
        rst_n = 1'b1;
        drive(0, 0, 0);

        // Basic 2x3 job, one result per cycle, ready held high
        setup(2, 3, 16'h100, 8);
        drive(1, 0, 1);
        repeat (6) drive(0, 1, 1);
        finish_job(1);

        // Backpressure: four words with ready low for six cycles
        setup(2, 2, 16'h200, 16'h10);
        drive(1, 0, 0);
        repeat (4) drive(0, 1, 0);
        repeat (2) drive(0, 0, 0);
        finish_job(1);

        // Overflow: fifth word into a full FIFO is dropped; error sticks
        setup(2, 4, 16'h300, 4);
        drive(1, 0, 0);
        repeat (5) drive(0, 1, 0);
        repeat (4) drive(0, 0, 1);
        repeat (4) drive(0, 1, 1);
        finish_job(1);
        repeat (2) drive(0, 0, 0);

        // Full FIFO with simultaneous pop and push
        setup(4, 2, 16'h400, 2);
        drive(1, 0, 0);
        repeat (4) drive(0, 1, 0);
        repeat (4) drive(0, 1, 1);
        finish_job(1);

        // Zero sizes, and a stray result in Idle
        setup(3, 0, 16'h500, 1);
        drive(1, 0, 1);
        finish_job(1);
        setup(0, 2, 16'h500, 1);
        drive(1, 0, 1);
        finish_job(1);
        drive(0, 1, 1);
        drive(0, 0, 1);

        // Address wrap at the top of the 16-bit space
        setup(1, 4, 16'hFFFE, 0);
        drive(1, 0, 1);
        repeat (4) drive(0, 1, 1);
        finish_job(1);

        // Reset after two of six writes, then restart
        setup(2, 3, 16'h600, 8);
        drive(1, 0, 1);
        repeat (3) drive(0, 1, 1);
        rst_n = 1'b0;
        drive(0, 0, 1);
        rst_n = 1'b1;
        drive(0, 0, 1);
        drive(1, 0, 1);
        repeat (6) drive(0, 1, 1);
        finish_job(1);

        // Randomized jobs with random ready, bursts and ignored starts
        for (int j = 0; j < 25; j++) begin
            setup($urandom_range(1, 3), $urandom_range(1, 4), $urandom, $urandom_range(0, 40));
            drive(1, 0, $urandom_range(0, 1));
            for (int c = 0; c < 120 && (m_run || m_done); c++) begin
                bit want;
                want = m_run && (m_k + m_q.size() < m_M * m_N) && ($urandom_range(0, 9) < 7);
                drive($urandom_range(0, 19) == 0, want, $urandom_range(0, 9) < 6);
            end
            drive(0, 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
